axilite_slave_regfile: RTL and testbench

AXI4-Lite responder (slave) that serves a bank of NUM_REGS read/write registers of DATA_W bits. It is the target-side counterpart of the team's AXI-Lite master and is intended to sit behind it or behind an interconnect as a control/status register block. The write and read channels are handled independently, with byte-strobe writes, DECERR on out-of-range addresses, and per-register write-commit pulses for downstream logic.

---
 rtl/axilite_slave_regfile.sv | 157 +++++++++++++++
 tb/tb_axilite_slave_regfile.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_slave_regfile.sv
// AXI4-Lite slave serving NUM_REGS byte-strobed registers with DECERR on out-of-range
// addresses and a one-cycle write-commit pulse per register.
module axilite_slave_regfile #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [ADDR_W-1:0]            s_axi_awaddr,
  input  logic [2:0]                   s_axi_awprot,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [DATA_W-1:0]            s_axi_wdata,
  input  logic [DATA_W/8-1:0]          s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [ADDR_W-1:0]            s_axi_araddr,
  input  logic [2:0]                   s_axi_arprot,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [DATA_W-1:0]            s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic [NUM_REGS-1:0]          reg_wr_pulse
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam logic [ADDR_W-1:0] NREGS_A = ADDR_W'(NUM_REGS);

  logic                r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]          r_bresp, r_rresp;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_aw_held, r_w_held;
  logic [ADDR_W-1:0]   r_aw_addr;
  logic [DATA_W-1:0]   r_w_data;
  logic [STRB_W-1:0]   r_w_strb;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_pulse;

  logic                w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_commit;
  logic                w_aw_held_nxt, w_w_held_nxt, w_bvalid_nxt, w_rvalid_nxt;
  logic [ADDR_W-1:0]   w_waddr, w_widx, w_ridx;
  logic [DATA_W-1:0]   w_wdata, w_rsel;
  logic [STRB_W-1:0]   w_wstrb;
  logic                w_win, w_rin;
  logic                w_unused;

  assign w_unused = ^{s_axi_awprot, s_axi_arprot};

  assign w_aw_hs = s_axi_awvalid & r_awready;
  assign w_w_hs  = s_axi_wvalid & r_wready;
  assign w_ar_hs = s_axi_arvalid & r_arready;
  assign w_r_hs  = r_rvalid & s_axi_rready;

  // Commit fires on whichever edge completes the second of the AW/W pair.
  assign w_commit      = (w_aw_hs | r_aw_held) & (w_w_hs | r_w_held);
  assign w_aw_held_nxt = (w_aw_hs | r_aw_held) & ~w_commit;
  assign w_w_held_nxt  = (w_w_hs | r_w_held) & ~w_commit;
  assign w_bvalid_nxt  = w_commit | (r_bvalid & ~s_axi_bready);
  assign w_rvalid_nxt  = w_ar_hs | (r_rvalid & ~s_axi_rready);

  assign w_waddr = w_aw_hs ? s_axi_awaddr : r_aw_addr;
  assign w_wdata = w_w_hs  ? s_axi_wdata  : r_w_data;
  assign w_wstrb = w_w_hs  ? s_axi_wstrb  : r_w_strb;
  assign w_widx  = w_waddr >> LSB;
  assign w_ridx  = s_axi_araddr >> LSB;
  assign w_win   = w_widx < NREGS_A;
  assign w_rin   = w_ridx < NREGS_A;

  always_comb begin
    w_rsel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_ridx == ADDR_W'(i)) w_rsel = r_regs[i];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      if (w_aw_hs) r_aw_addr <= s_axi_awaddr;
      if (w_w_hs) begin
        r_w_data <= s_axi_wdata;
        r_w_strb <= s_axi_wstrb;
      end
      r_awready <= ~w_aw_held_nxt & ~w_bvalid_nxt;
      r_wready  <= ~w_w_held_nxt & ~w_bvalid_nxt;
      r_bvalid  <= w_bvalid_nxt;
      if (w_commit) r_bresp <= w_win ? 2'b00 : 2'b11;
    end
  end

  // Out-of-range indices never match a register, so they neither write nor pulse.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_wr_pulse[i] <= w_commit & (w_widx == ADDR_W'(i));
        if (w_commit && (w_widx == ADDR_W'(i)))
          for (int b = 0; b < STRB_W; b++)
            if (w_wstrb[b]) r_regs[i][b*8 +: 8] <= w_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
    end else begin
      r_rvalid  <= w_rvalid_nxt;
      r_arready <= ~w_rvalid_nxt;
      if (w_ar_hs) begin
        r_rdata <= w_rsel;
        r_rresp <= w_rin ? 2'b00 : 2'b11;
      end else if (w_r_hs) begin
        r_rdata <= '0;
        r_rresp <= 2'b00;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_out
    assign reg_out[gi*DATA_W +: DATA_W] = r_regs[gi];
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign reg_wr_pulse  = r_wr_pulse;

endmodule

// File: tb/tb_axilite_slave_regfile.sv
// Bench for axilite_slave_regfile: transaction-level queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_axilite_slave_regfile;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 16;

  logic                       aclk = 1'b0;
  logic                       aresetn = 1'b0;
  logic [ADDR_W-1:0]          s_axi_awaddr = '0;
  logic [2:0]                 s_axi_awprot = 3'b000;
  logic                       s_axi_awvalid = 1'b0;
  logic                       s_axi_awready;
  logic [DATA_W-1:0]          s_axi_wdata = '0;
  logic [DATA_W/8-1:0]        s_axi_wstrb = '0;
  logic                       s_axi_wvalid = 1'b0;
  logic                       s_axi_wready;
  logic [1:0]                 s_axi_bresp;
  logic                       s_axi_bvalid;
  logic                       s_axi_bready = 1'b1;
  logic [ADDR_W-1:0]          s_axi_araddr = '0;
  logic [2:0]                 s_axi_arprot = 3'b000;
  logic                       s_axi_arvalid = 1'b0;
  logic                       s_axi_arready;
  logic [DATA_W-1:0]          s_axi_rdata;
  logic [1:0]                 s_axi_rresp;
  logic                       s_axi_rvalid;
  logic                       s_axi_rready = 1'b1;
  logic [NUM_REGS*DATA_W-1:0] reg_out;
  logic [NUM_REGS-1:0]        reg_wr_pulse;

  int checks = 0;
  int failures = 0;

  axilite_slave_regfile #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: transaction queues and a register array.
  logic [63:0]         m_mem [NUM_REGS];
  logic [31:0]         m_awq [$];
  logic [63:0]         m_wdq [$];
  logic [7:0]          m_wsq [$];
  logic [1:0]          m_bq  [$];
  logic [65:0]         m_rq  [$];
  logic [NUM_REGS-1:0] m_pulse;
  bit                  m_live;
  logic [31:0]         m_ridx, m_widx;
  logic [63:0]         m_d;
  logic [7:0]          m_s;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_awq.delete(); m_wdq.delete(); m_wsq.delete(); m_bq.delete(); m_rq.delete();
      m_pulse = '0;
      m_live  = 0;
    end else begin
      m_pulse = '0;
      if (m_bq.size() > 0 && s_axi_bready) void'(m_bq.pop_front());
      if (m_rq.size() > 0 && s_axi_rready) void'(m_rq.pop_front());
      if (s_axi_arvalid && s_axi_arready) begin
        m_ridx = s_axi_araddr / 8;
        if (m_ridx < NUM_REGS) m_rq.push_back({2'b00, m_mem[m_ridx]});
        else                   m_rq.push_back({2'b11, 64'h0});
      end
      if (s_axi_awvalid && s_axi_awready) m_awq.push_back(s_axi_awaddr);
      if (s_axi_wvalid && s_axi_wready) begin
        m_wdq.push_back(s_axi_wdata);
        m_wsq.push_back(s_axi_wstrb);
      end
      if (m_awq.size() > 0 && m_wdq.size() > 0) begin
        m_widx = m_awq.pop_front() / 8;
        m_d = m_wdq.pop_front();
        m_s = m_wsq.pop_front();
        if (m_widx < NUM_REGS) begin
          for (int b = 0; b < 8; b++)
            if (m_s[b]) m_mem[m_widx][8*b +: 8] = m_d[8*b +: 8];
          m_pulse[m_widx] = 1'b1;
          m_bq.push_back(2'b00);
        end else begin
          m_bq.push_back(2'b11);
        end
      end
      m_live = 1;
    end
  end

  always @(negedge aclk) begin
    chk("awready", 64'(s_axi_awready), 64'(m_live && m_awq.size() == 0 && m_bq.size() == 0));
    chk("wready",  64'(s_axi_wready),  64'(m_live && m_wdq.size() == 0 && m_bq.size() == 0));
    chk("arready", 64'(s_axi_arready), 64'(m_live && m_rq.size() == 0));
    chk("bvalid",  64'(s_axi_bvalid),  64'(m_bq.size() > 0));
    if (m_bq.size() > 0) chk("bresp", 64'(s_axi_bresp), 64'(m_bq[0]));
    chk("rvalid",  64'(s_axi_rvalid),  64'(m_rq.size() > 0));
    if (m_rq.size() > 0) begin
      chk("rdata", s_axi_rdata, m_rq[0][63:0]);
      chk("rresp", 64'(s_axi_rresp), 64'(m_rq[0][65:64]));
    end else begin
      chk("rdata_idle", s_axi_rdata, 64'h0);
    end
    chk("wr_pulse", 64'(reg_wr_pulse), 64'(m_pulse));
    for (int i = 0; i < NUM_REGS; i++)
      chk($sformatf("reg_out[%0d]", i), reg_out[i*DATA_W +: DATA_W], m_mem[i]);
  end

  task automatic send_aw(input logic [31:0] a, input int dly);
    int n = 0;
    repeat (dly) @(negedge aclk);
    s_axi_awaddr  = a;
    s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < 50) begin @(negedge aclk); n++; end
    chk("aw_accept", 64'(s_axi_awready), 64'd1);
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s, input int dly);
    int n = 0;
    repeat (dly) @(negedge aclk);
    s_axi_wdata  = d;
    s_axi_wstrb  = s;
    s_axi_wvalid = 1'b1;
    while (!s_axi_wready && n < 50) begin @(negedge aclk); n++; end
    chk("w_accept", 64'(s_axi_wready), 64'd1);
    @(negedge aclk);
    s_axi_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 50) begin @(negedge aclk); n++; end
    chk("ar_accept", 64'(s_axi_arready), 64'd1);
    @(negedge aclk);
    s_axi_arvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           input int aw_dly, input int w_dly);
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [63:0] d, output logic [1:0] r);
    int n = 0;
    send_ar(a);
    while (!s_axi_rvalid && n < 50) begin @(negedge aclk); n++; end
    chk("r_arrive", 64'(s_axi_rvalid), 64'd1);
    d = s_axi_rdata;
    r = s_axi_rresp;
    @(negedge aclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [1:0]  r;
    repeat (3) @(negedge aclk);
    chk("rst_awready", 64'(s_axi_awready), 64'd0);
    chk("rst_arready", 64'(s_axi_arready), 64'd0);
    chk("rst_bvalid",  64'(s_axi_bvalid),  64'd0);
    chk("rst_rdata",   s_axi_rdata,        64'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_awready", 64'(s_axi_awready), 64'd1);

    // Same-cycle AW/W then read back
    axi_write(32'h08, 64'h1122334455667788, 8'hFF, 0, 0);
    chk("t1_bvalid", 64'(s_axi_bvalid), 64'd1);
    chk("t1_bresp",  64'(s_axi_bresp),  64'd0);
    chk("t1_pulse",  64'(reg_wr_pulse), 64'h0002);
    @(negedge aclk);
    read_reg(32'h08, d, r);
    chk("t1_rdata", d, 64'h1122334455667788);
    chk("t1_rresp", 64'(r), 64'd0);

    // W leads AW by 3 cycles, partial strobe over all-ones
    axi_write(32'h10, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 0, 0);
    @(negedge aclk);
    axi_write(32'h10, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 3, 0);
    chk("t2_reg2",   reg_out[2*DATA_W +: DATA_W], 64'hFFFFFFFF_BBBBBBBB);
    chk("t2_pulse",  64'(reg_wr_pulse), 64'h0004);
    chk("t2_bvalid", 64'(s_axi_bvalid), 64'd1);
    @(negedge aclk);
    chk("t2_bdone",  64'(s_axi_bvalid), 64'd0);

    // Out-of-range write and read
    axi_write(32'h80, 64'hDEADBEEF_0BADF00D, 8'hFF, 0, 0);
    chk("t3_bresp", 64'(s_axi_bresp), 64'd3);
    chk("t3_pulse", 64'(reg_wr_pulse), 64'd0);
    chk("t3_reg1",  reg_out[1*DATA_W +: DATA_W], 64'h1122334455667788);
    @(negedge aclk);
    read_reg(32'h80, d, r);
    chk("t3_rdata", d, 64'd0);
    chk("t3_rresp", 64'(r), 64'd3);

    // B back-pressure blocks the next AW
    s_axi_bready = 1'b0;
    axi_write(32'h28, 64'h5555, 8'hFF, 0, 0);
    fork
      send_aw(32'h30, 0);
      begin
        repeat (5) @(negedge aclk);
        chk("t4_bvalid",  64'(s_axi_bvalid),  64'd1);
        chk("t4_bresp",   64'(s_axi_bresp),   64'd0);
        chk("t4_awready", 64'(s_axi_awready), 64'd0);
        chk("t4_wready",  64'(s_axi_wready),  64'd0);
        s_axi_bready = 1'b1;
      end
    join
    send_w(64'h66, 8'hFF, 0);
    chk("t4_reg5", reg_out[5*DATA_W +: DATA_W], 64'h5555);
    chk("t4_reg6", reg_out[6*DATA_W +: DATA_W], 64'h66);
    @(negedge aclk);

    // Same-edge write and read of reg3 returns the old value
    axi_write(32'h18, 64'h9, 8'hFF, 0, 0);
    @(negedge aclk);
    s_axi_rready = 1'b0;
    fork
      send_aw(32'h18, 0);
      send_w(64'h5, 8'hFF, 0);
      send_ar(32'h18);
    join
    chk("t5_rvalid", 64'(s_axi_rvalid), 64'd1);
    chk("t5_rdata",  s_axi_rdata, 64'h9);
    chk("t5_reg3",   reg_out[3*DATA_W +: DATA_W], 64'h5);
    repeat (2) begin
      @(negedge aclk);
      chk("t5_rhold", s_axi_rdata, 64'h9);
    end
    s_axi_rready = 1'b1;
    @(negedge aclk);
    chk("t5_rdone", 64'(s_axi_rvalid), 64'd0);
    chk("t5_rzero", s_axi_rdata, 64'd0);

    // Reset between AW and W discards the pending write
    send_aw(32'h20, 0);
    #2 aresetn = 1'b0;
    #1;
    chk("t6_awready", 64'(s_axi_awready), 64'd0);
    chk("t6_wready",  64'(s_axi_wready),  64'd0);
    chk("t6_arready", 64'(s_axi_arready), 64'd0);
    chk("t6_bvalid",  64'(s_axi_bvalid),  64'd0);
    chk("t6_pulse",   64'(reg_wr_pulse),  64'd0);
    chk("t6_reg1",    reg_out[1*DATA_W +: DATA_W], 64'd0);
    chk("t6_reg3",    reg_out[3*DATA_W +: DATA_W], 64'd0);
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b1;
    #1;
    chk("t6_rel_awready0", 64'(s_axi_awready), 64'd0);
    chk("t6_rel_wready0",  64'(s_axi_wready),  64'd0);
    @(negedge aclk);
    chk("t6_rel_awready1", 64'(s_axi_awready), 64'd1);
    chk("t6_rel_wready1",  64'(s_axi_wready),  64'd1);
    repeat (3) @(negedge aclk);
    chk("t6_no_b", 64'(s_axi_bvalid), 64'd0);
    chk("t6_reg4", reg_out[4*DATA_W +: DATA_W], 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
